dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request accept and data access (legal 0..15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 128, meaning the number of 16-bit storage words.
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_byte  input  1  1 = byte access, 0 = halfword access.
REQ-009 The block SHALL have port req_addr  input  16  byte address.
REQ-010 The block SHALL have port req_wdata  input  16  store data; byte stores use [7:0].
REQ-011 The block SHALL have port resp_valid  output  1  response present.
REQ-012 The block SHALL have port resp_ready  input  1  initiator accepts the response.
REQ-013 The block SHALL have port resp_rdata  output  16  load data.
REQ-014 The block SHALL have port resp_err  output  1  access was illegal; no side effect occurred.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; write, byte, addr and wdata SHALL be captured at accept.
REQ-018 On accept, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES; if WAIT_CYCLES=0, it SHALL go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it reaches 0, the access SHALL be performed and the FSM SHALL go to RESP.
REQ-020 Latency: for an accept on cycle N, resp_valid SHALL first be 1 on cycle N+1+WAIT_CYCLES.
REQ-021 In RESP, resp_valid SHALL be held at 1, with resp_rdata and resp_err stable, until resp_ready=1.
REQ-022 The response handshake cycle SHALL return the FSM to IDLE; the earliest next accept is the following cycle; one outstanding request maximum.
REQ-023 Byte order SHALL be big-endian: the even byte address maps to word[15:8] and the odd byte address maps to word[7:0].
REQ-024 A byte load SHALL return the addressed byte in resp_rdata[7:0] with [15:8]=0; sign extension is the CPU's job.
REQ-025 A halfword load SHALL return the full word at addr[15:1].
REQ-026 A byte store SHALL update only the addressed byte lane; a halfword store SHALL update both lanes.
REQ-027 A store SHALL respond with resp_rdata=0 and resp_err=0.
REQ-028 A misaligned halfword access (addr[0]=1) SHALL set resp_err=1 and resp_rdata=0, with no write.
REQ-029 An address >= 2*DEPTH_WORDS SHALL set resp_err=1 and resp_rdata=0, with no write.
REQ-030 req_valid while not in IDLE SHALL be ignored; the request is not captured.
REQ-031 resp_ready while not in RESP SHALL be ignored.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL take: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-033 While rst=1, req_ready SHALL be 0; it SHALL be 1 on the first cycle after rst deasserts.
REQ-034 All storage words SHALL be cleared to 0 on reset.
REQ-035 Reset during WAIT SHALL abort the pending store, with no memory update; reset during RESP SHALL drop the response.

Structure
REQ-036 A shared definitions package dmem_defs SHALL hold the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the address and data widths (16) and the access-size encodings.
REQ-037 Storage SHALL be a single sub-module dmem_array: DEPTH_WORDS x 16 bits, synchronous write with two byte-lane enables, combinational read, synchronous clear on rst.
REQ-038 The FSM, counter, address decode and error logic SHALL reside in dmem_responder.

Verification
REQ-039 Scenario: WAIT_CYCLES=2; halfword store addr 0x0010 data 0xBEEF accepted cycle 5, then halfword load 0x0010 -> store resp_valid on cycle 8, err=0; load rdata=0xBEEF.
REQ-040 Scenario: byte store 0xAA to 0x0021, then byte loads 0x0020 and 0x0021 -> 0x0000 and 0x00AA; halfword load 0x0020 -> 0x00AA.
REQ-041 Scenario: halfword load 0x0003; then store 0x0100 with DEPTH_WORDS=128 -> both resp_err=1 and rdata=0; a later load of 0x00FE returns its prior value, unchanged.
REQ-042 Scenario: hold resp_ready=0 for 4 cycles in RESP, with req_valid=1 throughout -> resp_valid and rdata stay stable, req_ready stays 0, and no second accept occurs until the cycle after the response handshake.
REQ-043 Scenario: WAIT_CYCLES=0, back-to-back requests with resp_ready=1 -> each response arrives 1 cycle after accept, and an accept occurs every 2 cycles.
REQ-044 Scenario: store 0x1234 to 0x0040, with rst asserted in its WAIT state -> outputs are at reset values next cycle, and a load of 0x0040 after reset returns 0x0000.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared definitions for the data-memory responder
package dmem_defs;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        SIZE_HALF = 1'b0,
        SIZE_BYTE = 1'b1
    } size_t;

    // Big-endian lane select: the even byte address lives in the upper half of the word.
    function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] word, input logic odd);
        return odd ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with two byte-lane write enables and clear on reset
module dmem_array
    import dmem_defs::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we_hi) mem[idx][15:8] <= wdata[15:8];
            if (we_lo) mem[idx][7:0]  <= wdata[7:0];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable wait states
module dmem_responder
    import dmem_defs::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int              IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(2 * DEPTH_WORDS);

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              cap_write, cap_byte;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept, do_access;
    logic              op_write, op_byte, op_err;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata, word_rd, word_wd, access_rdata;
    logic              we_hi, we_lo;

    assign accept = req_valid && req_ready;

    // With no wait states the access is done on the accept edge, straight from the request inputs.
    assign do_access = (state == IDLE && accept && WAIT_INIT == 4'd0) ||
                       (state == WAIT && cnt == 4'd1);

    assign op_write = (state == IDLE) ? req_write : cap_write;
    assign op_byte  = (state == IDLE) ? req_byte  : cap_byte;
    assign op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : cap_wdata;

    assign op_err = (op_byte == SIZE_HALF && op_addr[0]) || ({1'b0, op_addr} >= ADDR_LIMIT);

    assign word_wd = (op_byte == SIZE_BYTE) ? {op_wdata[7:0], op_wdata[7:0]} : op_wdata;
    assign we_hi   = do_access && op_write && !op_err && !rst && (op_byte == SIZE_HALF || !op_addr[0]);
    assign we_lo   = do_access && op_write && !op_err && !rst && (op_byte == SIZE_HALF ||  op_addr[0]);

    assign access_rdata = (op_write || op_err)  ? '0 :
                          (op_byte == SIZE_BYTE) ? {8'd0, pick_byte(word_rd, op_addr[0])} :
                                                   word_rd;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .idx   (op_addr[IDX_W:1]),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (word_wd),
        .rdata (word_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_INIT == 4'd0) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = RESP;
            end
            RESP: begin
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        if (state == IDLE && !rst) req_ready = 1'b1;
        if (state == RESP)         resp_valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_write  <= 1'b0;
            cap_byte   <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_write <= req_write;
                cap_byte  <= req_byte;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (do_access) begin
                resp_rdata <= access_rdata;
                resp_err   <= op_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (2 wait states and 0 wait states)
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic        a_req_valid, a_req_ready, a_req_write, a_req_byte;
    logic [15:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_byte;
    logic [15:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic        z_resp_valid, z_resp_ready, z_resp_err;

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(128)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_byte(a_req_byte), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(128)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_byte(z_req_byte), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    logic [15:0] mdl [2][128];
    logic [16:0] a_exp_q[$];
    logic [16:0] z_exp_q[$];
    int          a_acc_cnt = 0;

    always @(negedge clk) begin
        if (!rst && a_req_valid && a_req_ready) a_acc_cnt++;
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 128; i++) mdl[d][i] = 16'h0000;
        a_exp_q.delete();
        z_exp_q.delete();
    endtask

    // Expected {err, rdata}; stores also update the reference memory.
    task automatic model(input int d, input logic w, input logic b, input logic [15:0] addr,
                         input logic [15:0] wd, output logic [16:0] e);
        int idx;
        idx = int'(addr[15:1]);
        if ((!b && addr[0]) || addr >= 16'd256) begin
            e = {1'b1, 16'h0000};
        end else if (w) begin
            if (!b)          mdl[d][idx]       = wd;
            else if (addr[0]) mdl[d][idx][7:0]  = wd[7:0];
            else              mdl[d][idx][15:8] = wd[7:0];
            e = 17'h0;
        end else if (!b) begin
            e = {1'b0, mdl[d][idx]};
        end else begin
            e = {1'b0, 8'h00, (addr[0] ? mdl[d][idx][7:0] : mdl[d][idx][15:8])};
        end
    endtask

    task automatic do_a(input logic w, input logic b, input logic [15:0] addr, input logic [15:0] wd);
        logic [16:0] e;
        int acc;
        bit ok;
        model(0, w, b, addr, wd, e);
        a_exp_q.push_back(e);
        a_req_write = w; a_req_byte = b; a_req_addr = addr; a_req_wdata = wd;
        a_req_valid = 1'b1; a_resp_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_req_ready) begin acc = cyc; ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL accept_timeout addr=%h got no accept want accept", addr);
            a_req_valid = 1'b0; void'(a_exp_q.pop_back()); return;
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_resp_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL resp_timeout addr=%h got no resp_valid want resp_valid", addr);
            void'(a_exp_q.pop_front()); return;
        end
        total++;
        if (cyc !== acc + 3) begin
            bad++; $display("FAIL latency addr=%h got %0d want %0d", addr, cyc - acc, 3);
        end
        e = a_exp_q.pop_front();
        total++;
        if ({a_resp_err, a_resp_rdata} !== e) begin
            bad++; $display("FAIL resp addr=%h got err=%0b rdata=%h want err=%0b rdata=%h",
                            addr, a_resp_err, a_resp_rdata, e[16], e[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_byte = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_byte = 0; z_req_addr = 0; z_req_wdata = 0; z_resp_ready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata} !== 19'h0) begin
            bad++; $display("FAIL reset_a got ready=%0b valid=%0b err=%0b rdata=%h want all zero",
                            a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata);
        end
        total++;
        if ({z_req_ready, z_resp_valid, z_resp_err, z_resp_rdata} !== 19'h0) begin
            bad++; $display("FAIL reset_z got ready=%0b valid=%0b err=%0b rdata=%h want all zero",
                            z_req_ready, z_resp_valid, z_resp_err, z_resp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (a_req_ready !== 1'b1 || z_req_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_reset got a=%0b z=%0b want 1 1", a_req_ready, z_req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        do_a(1, 0, 16'h0010, 16'hBEEF);
        do_a(0, 0, 16'h0010, 16'h0000);
    endtask

    task automatic test_byte_lanes();
        do_a(1, 1, 16'h0021, 16'h77AA);
        do_a(0, 1, 16'h0020, 16'h0000);
        do_a(0, 1, 16'h0021, 16'h0000);
        do_a(0, 0, 16'h0020, 16'h0000);
        do_a(1, 1, 16'h0020, 16'h3355);
        do_a(0, 0, 16'h0020, 16'h0000);
    endtask

    task automatic test_errors();
        do_a(1, 0, 16'h00FE, 16'h5A5A);
        do_a(0, 0, 16'h0003, 16'h0000);
        do_a(1, 0, 16'h0100, 16'h1111);
        do_a(1, 0, 16'h00FF, 16'h2222);
        do_a(1, 1, 16'h0101, 16'h0033);
        do_a(0, 0, 16'h00FE, 16'h0000);
        do_a(0, 1, 16'h00FF, 16'h0000);
        do_a(0, 0, 16'h0000, 16'h0000);
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        int acc, acc2, base;
        bit ok;
        model(0, 0, 0, 16'h0010, 16'h0000, e);
        a_exp_q.push_back(e);
        a_exp_q.push_back(e);
        a_req_write = 0; a_req_byte = 0; a_req_addr = 16'h0010; a_req_wdata = 16'h0;
        a_req_valid = 1'b1; a_resp_ready = 1'b0;
        base = a_acc_cnt;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_req_ready) begin acc = cyc; ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL bp_accept got no accept want accept"); end
        @(posedge clk); #1;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_resp_valid) begin ok = 1; break; end
        end
        total++;
        if (!ok || cyc !== acc + 3) begin
            bad++; $display("FAIL bp_latency got %0d want 3", cyc - acc);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a_resp_valid !== 1'b1 || {a_resp_err, a_resp_rdata} !== e || a_req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold k=%0d got valid=%0b err=%0b rdata=%h ready=%0b want 1 %0b %h 0",
                                k, a_resp_valid, a_resp_err, a_resp_rdata, a_req_ready, e[16], e[15:0]);
            end
            @(posedge clk); #1;
            total++;
            if (a_acc_cnt !== base + 1) begin
                bad++; $display("FAIL bp_no_accept got %0d want %0d", a_acc_cnt - base, 1);
            end
            if (k < 3) @(negedge clk);
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        e = a_exp_q.pop_front();
        total++;
        if (a_resp_valid !== 1'b1 || {a_resp_err, a_resp_rdata} !== e || a_req_ready !== 1'b0) begin
            bad++; $display("FAIL bp_handshake got valid=%0b err=%0b rdata=%h ready=%0b want 1 %0b %h 0",
                            a_resp_valid, a_resp_err, a_resp_rdata, a_req_ready, e[16], e[15:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        acc2 = cyc;
        total++;
        if (a_req_ready !== 1'b1) begin
            bad++; $display("FAIL bp_next_accept got ready=%0b want 1", a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        total++;
        if (a_acc_cnt !== base + 2) begin
            bad++; $display("FAIL bp_second_accept got %0d want %0d", a_acc_cnt - base, 2);
        end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_resp_valid) begin ok = 1; break; end
        end
        e = a_exp_q.pop_front();
        total++;
        if (!ok || cyc !== acc2 + 3 || {a_resp_err, a_resp_rdata} !== e) begin
            bad++; $display("FAIL bp_second_resp got lat=%0d err=%0b rdata=%h want lat=3 err=%0b rdata=%h",
                            cyc - acc2, a_resp_err, a_resp_rdata, e[16], e[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic        tw [6] = '{1, 0, 1, 0, 0, 0};
        logic        tb [6] = '{0, 0, 1, 0, 1, 0};
        logic [15:0] ta [6] = '{16'h0002, 16'h0002, 16'h0003, 16'h0002, 16'h0002, 16'h0001};
        logic [15:0] td [6] = '{16'hCAFE, 16'h0000, 16'h9911, 16'h0000, 16'h0000, 16'h0000};
        logic [16:0] e;
        int acc, acc_prev;
        bit ok;
        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        acc_prev = 0;
        for (int i = 0; i < 6; i++) begin
            model(1, tw[i], tb[i], ta[i], td[i], e);
            z_exp_q.push_back(e);
            z_req_write = tw[i]; z_req_byte = tb[i]; z_req_addr = ta[i]; z_req_wdata = td[i];
            ok = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (z_req_ready) begin acc = cyc; ok = 1; break; end
            end
            total++;
            if (!ok) begin
                bad++; $display("FAIL b2b_accept i=%0d got no accept want accept", i);
                break;
            end
            if (i > 0) begin
                total++;
                if (acc - acc_prev !== 2) begin
                    bad++; $display("FAIL b2b_spacing i=%0d got %0d want 2", i, acc - acc_prev);
                end
            end
            acc_prev = acc;
            @(negedge clk);
            e = z_exp_q.pop_front();
            total++;
            if (z_resp_valid !== 1'b1 || {z_resp_err, z_resp_rdata} !== e) begin
                bad++; $display("FAIL b2b_resp i=%0d got valid=%0b err=%0b rdata=%h want 1 %0b %h",
                                i, z_resp_valid, z_resp_err, z_resp_rdata, e[16], e[15:0]);
            end
        end
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        a_req_write = 1; a_req_byte = 0; a_req_addr = 16'h0040; a_req_wdata = 16'h1234;
        a_req_valid = 1'b1; a_resp_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_req_ready) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rw_accept got no accept want accept"); end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        total++;
        if ({a_resp_valid, a_resp_err, a_resp_rdata} !== 18'h0 || a_req_ready !== 1'b1) begin
            bad++; $display("FAIL rw_outputs got valid=%0b err=%0b rdata=%h ready=%0b want 0 0 0000 1",
                            a_resp_valid, a_resp_err, a_resp_rdata, a_req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (a_resp_valid !== 1'b0) begin
                bad++; $display("FAIL rw_dropped k=%0d got valid=%0b want 0", k, a_resp_valid);
            end
        end
        @(posedge clk); #1;
        do_a(0, 0, 16'h0040, 16'h0000);
        do_a(0, 0, 16'h0010, 16'h0000);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
